csa_stream_accumulator: RTL and testbench

//  Sums a packetised stream of DATA_W-bit operands, keeping the running total in carry-save form.

---
 rtl/csa_acc_pkg.sv | 21 ++
 rtl/csa_3to2.sv | 16 +
 rtl/csa_stream_accumulator.sv | 132 +++++++++++++
 tb/tb_csa_stream_accumulator.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_acc_pkg.sv
// Shared types and width helpers for the carry-save stream accumulator.
// The top module honours the CSA_ACC_SIGNED_EN macro (signed operands when defined).
package csa_acc_pkg;

    typedef enum logic [1:0] {
        ACC     = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Accumulator width: enough headroom for MAX_OPS full-scale operands.
    function automatic int acc_width(input int data_w, input int max_ops);
        return data_w + $clog2(max_ops);
    endfunction

    // Beat counter width: must be able to hold MAX_OPS itself.
    function automatic int cnt_width(input int max_ops);
        return $clog2(max_ops) + 1;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// Bitwise 3:2 compressor (full adder per bit). The carry is returned unshifted;
// the caller is responsible for aligning it one bit up.
module csa_3to2 #(
    parameter int W = 12
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] s_o,
    output logic [W-1:0] cy_o
);

    assign s_o  = a_i ^ b_i ^ c_i;
    assign cy_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Packet accumulator: carry-save running total, one CPA at end of packet.
// Define CSA_ACC_SIGNED_EN for two's-complement operands (sign extension).
module csa_stream_accumulator
    import csa_acc_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  MAX_OPS = 16,
    localparam int CNT_W   = cnt_width(MAX_OPS),
    localparam int ACC_W   = acc_width(DATA_W, MAX_OPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic [1:0]        dbg_state_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_s_q, acc_s_d;
    logic [ACC_W-1:0]   acc_c_q, acc_c_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]   ext_data;
    logic [ACC_W-1:0]   csa_s;
    logic [ACC_W-1:0]   csa_cy;

`ifdef CSA_ACC_SIGNED_EN
    assign ext_data = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
`else
    assign ext_data = {{(ACC_W-DATA_W){1'b0}}, in_data};
`endif

    csa_3to2 #(.W(ACC_W)) u_csa (
        .a_i  (acc_s_q),
        .b_i  (acc_c_q),
        .c_i  (ext_data),
        .s_o  (csa_s),
        .cy_o (csa_cy)
    );

    always_comb begin
        state_d     = state_q;
        acc_s_d     = acc_s_q;
        acc_c_d     = acc_c_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        sum_d       = sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        case (state_q)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_s_d = csa_s;
                    // Carry weight is one bit up; the bit shifted past ACC_W is a 2^ACC_W multiple.
                    acc_c_d = {csa_cy[ACC_W-2:0], 1'b0};
                    if (count_q == MAX_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                sum_d       = acc_s_q + acc_c_q;
                out_count_d = count_q;
                out_ovf_d   = ovf_q;
                state_d     = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_s_d = '0;
                    acc_c_d = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            sum_q       <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_s_q     <= acc_s_d;
            acc_c_q     <= acc_c_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            sum_q       <= sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_sum     = sum_q;
    assign out_count   = out_count_q;
    assign out_ovf     = out_ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Self-checking bench for csa_stream_accumulator (DATA_W=8, MAX_OPS=16).
module tb_csa_stream_accumulator;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 12;
  localparam int CNT_W  = 5;
  localparam int EXP_W  = ACC_W + CNT_W + 1;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;
  logic [1:0]        dbg_state;

  int n_checks;
  int n_pass;

  // Reference model state for the packet currently being driven
  logic [ACC_W-1:0] m_sum;
  logic [CNT_W-1:0] m_cnt;
  logic             m_ovf;

  logic [EXP_W-1:0] exp_q[$];

  csa_stream_accumulator #(.DATA_W(DATA_W), .MAX_OPS(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_count   (out_count),
    .out_ovf     (out_ovf),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Sampled 1 time unit after the falling edge: these are exactly the values the next rising edge sees.
  always begin
    logic [EXP_W-1:0] e;
    @(negedge clk);
    #1;
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL result_unexpected: got sum=%0h count=%0d ovf=%0b, required no result", out_sum, out_count, out_ovf);
      end else begin
        e = exp_q.pop_front();
        if ({out_sum, out_count, out_ovf} !== e) begin
          $display("FAIL result: got sum=%0h count=%0d ovf=%0b, required sum=%0h count=%0d ovf=%0b",
                   out_sum, out_count, out_ovf, e[EXP_W-1 -: ACC_W], e[CNT_W:1], e[0]);
        end else begin
          n_pass++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_clear();
    m_sum = '0;
    m_cnt = '0;
    m_ovf = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after the beat fired.
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
    logic [ACC_W-1:0] ext;
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL beat_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
    end
    @(negedge clk);
`ifdef CSA_ACC_SIGNED_EN
    ext = ACC_W'(signed'(d));
`else
    ext = ACC_W'(d);
`endif
    m_sum = m_sum + ext;
    if (m_cnt == CNT_W'(16)) m_ovf = 1'b1;
    else m_cnt = m_cnt + 1'b1;
    if (last) begin
      exp_q.push_back({m_sum, m_cnt, m_ovf});
      model_clear();
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if ({in_ready, out_valid, out_sum, out_count, out_ovf} !== {1'b1, 1'b0, 12'h0, 5'd0, 1'b0})
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b sum=%0h cnt=%0d ovf=%0b, required 1 0 0 0 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    else n_pass++;
    n_checks++;
    if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d, required 0", dbg_state);
    else n_pass++;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_beat(8'd3, 1'b0);
    send_beat(8'd5, 1'b0);
    send_beat(8'd7, 1'b1);
    idle();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL latency_k1: out_valid=%0b, required 0", out_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 12'd15 || out_count !== 5'd3)
      $display("FAIL latency_k2: vld=%0b sum=%0d cnt=%0d, required 1 15 3", out_valid, out_sum, out_count);
    else n_pass++;
    drain();
  endtask

  task automatic test_full_and_overflow();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_beat(8'hFF, i == 15);
    idle();
    drain();
    n_checks++;
    if ({out_sum, out_count, out_ovf} !== {12'hFF0, 5'd16, 1'b0})
      $display("FAIL full16: got sum=%0h cnt=%0d ovf=%0b, required ff0 16 0", out_sum, out_count, out_ovf);
    else n_pass++;
    for (int i = 0; i < 17; i++) send_beat(8'hFF, i == 16);
    idle();
    drain();
`ifndef CSA_ACC_SIGNED_EN
    n_checks++;
    if ({out_sum, out_count, out_ovf} !== {12'h0EF, 5'd16, 1'b1})
      $display("FAIL ovf17: got sum=%0h cnt=%0d ovf=%0b, required 0ef 16 1", out_sum, out_count, out_ovf);
    else n_pass++;
`endif
  endtask

  task automatic test_single();
    logic [ACC_W-1:0] want;
`ifdef CSA_ACC_SIGNED_EN
    want = 12'hF80;
`else
    want = 12'h080;
`endif
    out_ready = 1'b1;
    send_beat(8'h80, 1'b1);
    idle();
    drain();
    n_checks++;
    if (out_sum !== want || out_count !== 5'd1)
      $display("FAIL single: got sum=%0h cnt=%0d, required %0h 1", out_sum, out_count, want);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(8'd1, 1'b0);
    send_beat(8'd2, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL hold_ready[%0d]: got %0b, required 0", i, in_ready);
      else n_pass++;
      if (out_valid) begin
        n_checks++;
        if (out_sum !== 12'd3 || out_count !== 5'd2)
          $display("FAIL hold_sum[%0d]: got sum=%0d cnt=%0d, required 3 2", i, out_sum, out_count);
        else n_pass++;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    send_beat(8'd9, 1'b1);
    idle();
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send_beat(8'd4, 1'b0);
    send_beat(8'd4, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_sum, out_count, out_ovf} !== {1'b1, 1'b0, 12'h0, 5'd0, 1'b0})
      $display("FAIL async_reset: got rdy=%0b vld=%0b sum=%0h cnt=%0d ovf=%0b, required 1 0 0 0 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    else n_pass++;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(8'd6, 1'b1);
    idle();
    drain();
  endtask

  task automatic test_back_to_back();
    int len;
    out_ready = 1'b1;
    for (int p = 0; p < 6; p++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) send_beat(DATA_W'($urandom_range(0, 255)), i == len - 1);
    end
    idle();
    drain();
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_full_and_overflow();
    test_single();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
